// File: rtl/pipeline_disp_pkg.sv
// rtl/pipeline_disp_pkg.sv - shared types and constants for the pipeline display controller
package pipeline_disp_pkg;

  typedef enum logic {
    CLK_LO = 1'b0,
    CLK_HI = 1'b1
  } clk_state_t;

  localparam int DIGITS = 8;

  // Active-low {g,f,e,d,c,b,a}, index 15 (F) leftmost down to index 0.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser and debouncer with rising-level pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          sample_q, sample_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;

  // Any change of the synchronised input restarts the stability window.
  always_comb begin
    sample_d = sync2_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    if (sync2_q != sample_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      level_d = sample_q;
    end
    pulse_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sample_q <= 1'b0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: rtl/pipeline_display_ctrl.sv
// rtl/pipeline_display_ctrl.sv - processor clock generator and 8-digit hex display of PC/WriteData
// Optional upper-half display selected by macro PIPE_DISP_HIGH_HALF_EN.
module pipeline_display_ctrl
  import pipeline_disp_pkg::*;
#(
  parameter int PROC_HALF       = 50000000,
  parameter int REFRESH_DIV     = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        Clk,
  input  logic        Rst,
`ifdef PIPE_DISP_HIGH_HALF_EN
  input  logic        HalfSel,
`endif
  input  logic [31:0] WriteData,
  input  logic [31:0] PCValue,
  input  logic        StepMode,
  input  logic        StepBtn,
  output logic        ProcClk,
  output logic [7:0]  An,
  output logic [6:0]  Seg,
  output logic        Dp
);

  localparam int HW = $clog2(PROC_HALF);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [HW-1:0] HC_MAX = HW'(PROC_HALF - 1);
  localparam logic [RW-1:0] RC_MAX = RW'(REFRESH_DIV - 1);

  clk_state_t  state_q, state_d;
  logic [HW-1:0] hc_q, hc_d;
  logic [RW-1:0] rc_q, rc_d;
  logic [2:0]  d_q, d_d;
  logic        mode_s1_q, mode_s2_q;
  logic        proc_clk_q, proc_clk_d, proc_clk_d1_q;
  logic [31:0] pc_q, pc_d, wd_q, wd_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        cap_en, step_pulse, btn_level, half_s;
  logic [15:0] show_val;
  logic [3:0]  nib;

`ifdef PIPE_DISP_HIGH_HALF_EN
  logic half_s1_q, half_s2_q;
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      half_s1_q <= 1'b0;
      half_s2_q <= 1'b0;
    end else begin
      half_s1_q <= HalfSel;
      half_s2_q <= half_s1_q;
    end
  end
  assign half_s = half_s2_q;
`else
  assign half_s = 1'b0;
`endif

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
    .clk       (Clk),
    .rst_n     (Rst),
    .btn_raw   (StepBtn),
    .btn_level (btn_level),
    .btn_pulse (step_pulse)
  );

  // Mode is only sampled in CLK_LO, so a running high phase always completes.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    case (state_q)
      CLK_LO: begin
        if (mode_s2_q) begin
          hc_d = '0;
          if (step_pulse) state_d = CLK_HI;
        end else if (hc_q == HC_MAX) begin
          hc_d    = '0;
          state_d = CLK_HI;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      CLK_HI: begin
        if (hc_q == HC_MAX) begin
          hc_d    = '0;
          state_d = CLK_LO;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      default: begin
        hc_d    = '0;
        state_d = CLK_LO;
      end
    endcase
  end

  // Scan and segment data use the next-state values so a same-edge capture shows at once.
  always_comb begin
    proc_clk_d = (state_d == CLK_HI);
    cap_en     = proc_clk_q & ~proc_clk_d1_q;
    pc_d       = cap_en ? PCValue   : pc_q;
    wd_d       = cap_en ? WriteData : wd_q;
    rc_d       = (rc_q == RC_MAX) ? '0 : rc_q + 1'b1;
    d_d        = (rc_q == RC_MAX) ? d_q + 3'd1 : d_q;
    if (d_d[2]) show_val = half_s ? pc_d[31:16] : pc_d[15:0];
    else        show_val = half_s ? wd_d[31:16] : wd_d[15:0];
    nib        = show_val[{d_d[1:0], 2'b00} +: 4];
    seg_d      = SEG_HEX[nib];
    an_d       = ~(DIGITS'(1) << d_d);
    dp_d       = ~((d_d == 3'd4) || (half_s && (d_d == 3'd0)));
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= CLK_LO;
      hc_q          <= '0;
      rc_q          <= '0;
      d_q           <= '0;
      mode_s1_q     <= 1'b0;
      mode_s2_q     <= 1'b0;
      proc_clk_q    <= 1'b0;
      proc_clk_d1_q <= 1'b0;
      pc_q          <= '0;
      wd_q          <= '0;
      an_q          <= 8'hFF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      hc_q          <= hc_d;
      rc_q          <= rc_d;
      d_q           <= d_d;
      mode_s1_q     <= StepMode;
      mode_s2_q     <= mode_s1_q;
      proc_clk_q    <= proc_clk_d;
      proc_clk_d1_q <= proc_clk_q;
      pc_q          <= pc_d;
      wd_q          <= wd_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign ProcClk = proc_clk_q;
  assign An      = an_q;
  assign Seg     = seg_q;
  assign Dp      = dp_q;

endmodule

// File: tb/tb_pipeline_display_ctrl.sv
// tb/tb_pipeline_display_ctrl.sv - scoreboard bench for pipeline_display_ctrl
module tb_pipeline_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        half_sel = 1'b0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] pc_value = 32'h0;
  logic        step_mode = 1'b0;
  logic        step_btn = 1'b0;
  logic        proc_clk;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] wd;
  } exp_t;
  exp_t exp_q[$];

  bit          mon_en = 1'b0;
  logic [31:0] cur_pc, cur_wd;

  pipeline_display_ctrl #(
    .PROC_HALF(3), .REFRESH_DIV(4), .DEBOUNCE_CYCLES(5)
  ) dut (
    .Clk       (clk),
    .Rst       (rst_n),
`ifdef PIPE_DISP_HIGH_HALF_EN
    .HalfSel   (half_sel),
`endif
    .WriteData (write_data),
    .PCValue   (pc_value),
    .StepMode  (step_mode),
    .StepBtn   (step_btn),
    .ProcClk   (proc_clk),
    .An        (an),
    .Seg       (seg),
    .Dp        (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected segments/dp for whichever digit is currently enabled.
  task automatic chk_disp(input logic [31:0] pc, input logic [31:0] wd, input logic half);
    int k = -1;
    logic [7:0]  pat;
    logic [31:0] val;
    int sh;
    for (int i = 0; i < 8; i++) begin
      pat = ~(8'b1 << i);
      if (an === pat) k = i;
    end
    chk("an_onehot", (k >= 0) ? 32'd1 : 32'd0, 32'd1);
    if (k >= 0) begin
      val = (k >= 4) ? pc : wd;
      sh  = (half ? 16 : 0) + 4 * (k % 4);
      val = val >> sh;
      chk("seg", {25'b0, seg}, {25'b0, hex7(val[3:0])});
      chk("dp", {31'b0, dp}, ((k == 4) || (half && k == 0)) ? 32'd0 : 32'd1);
    end
  endtask

  // Monitor: one expected capture per ProcClk rise, shown from the following cycle.
  initial begin
    bit   prev = 1'b0;
    bit   pend = 1'b0;
    int   hi_cnt = 0;
    exp_t e;
    exp_t pend_e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pend) begin
          cur_pc = pend_e.pc;
          cur_wd = pend_e.wd;
          pend   = 1'b0;
        end
        if (proc_clk && !prev) begin
          chk("pulse_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
          if (exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            pend_e = e;
            pend   = 1'b1;
          end
          hi_cnt = 1;
        end else if (proc_clk) begin
          hi_cnt++;
        end else if (prev) begin
          chk("pulse_width", hi_cnt, 3);
        end
        chk_disp(cur_pc, cur_wd, half_sel);
      end
      prev = proc_clk;
    end
  end

  initial begin
    logic [7:0] ean;
    int w, hi, rises, nb, hold;
    bit press, prev;

    pc_value   = 32'h0000ABCD;
    write_data = 32'h00001234;
    repeat (3) @(negedge clk);
    chk("rst_procclk", {31'b0, proc_clk}, 32'd0);
    chk("rst_an", {24'b0, an}, 32'hFF);
    chk("rst_seg", {25'b0, seg}, 32'h7F);
    chk("rst_dp", {31'b0, dp}, 32'd1);

    // Free-run: ProcClk period 6, digit scan 4 cycles each, capture after first rise.
    rst_n = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      ean = ~(8'b1 << ((n / 4) % 8));
      chk("run_procclk", {31'b0, proc_clk}, ((n / 3) % 2 == 1) ? 32'd1 : 32'd0);
      chk("run_an", {24'b0, an}, {24'b0, ean});
      chk_disp((n >= 4) ? 32'h0000ABCD : 32'h0, (n >= 4) ? 32'h00001234 : 32'h0, 1'b0);
    end

    // Asynchronous reset in the middle of a high phase.
    w = 0;
    while (proc_clk !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk("mid_wait_high", {31'b0, proc_clk}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_procclk", {31'b0, proc_clk}, 32'd0);
    chk("mid_rst_an", {24'b0, an}, 32'hFF);
    chk("mid_rst_seg", {25'b0, seg}, 32'h7F);
    chk("mid_rst_dp", {31'b0, dp}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Switch to step mode during a high phase: the phase completes, then holds low.
    w = 0;
    while (proc_clk !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk("toggle_wait_high", {31'b0, proc_clk}, 32'd1);
    step_mode = 1'b1;
    hi = 0;
    while (proc_clk === 1'b1 && hi < 10) begin hi++; @(negedge clk); end
    chk("toggle_high_width", hi, 3);
    rises = 0;
    prev  = proc_clk;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (proc_clk && !prev) rises++;
      prev = proc_clk;
    end
    chk("toggle_hold_low", rises, 0);

`ifdef PIPE_DISP_HIGH_HALF_EN
    half_sel = 1'b1;
    repeat (4) @(negedge clk);
`endif
    cur_pc = 32'h0000ABCD;
    cur_wd = 32'h00001234;
    mon_en = 1'b1;

    // Step presses with bounce; inputs change freely while ProcClk is low.
    for (int it = 0; it < 10; it++) begin
      pc_value   = (it == 0) ? 32'hDEAD0000 : $urandom;
      write_data = $urandom;
      press      = (it < 2) || ($urandom_range(0, 3) != 0);
      nb         = (it == 0) ? 4 : $urandom_range(0, 3);
      hold       = $urandom_range(9, 14);
      if (press) begin
        exp_q.push_back('{pc: pc_value, wd: write_data});
        for (int b = 0; b < nb; b++) begin
          step_btn = 1'b1; repeat (2) @(negedge clk);
          step_btn = 1'b0; repeat (2) @(negedge clk);
        end
        step_btn = 1'b1;
        repeat (hold) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
          step_btn = 1'b0; @(negedge clk);
          step_btn = 1'b1; @(negedge clk);
        end
        step_btn = 1'b0;
      end
      repeat (40) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    chk("pending_pulses", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_display_ctrl.md
Name: pipeline_display_ctrl

Overview:
- Board-level consumer of the pipelined MIPS core's two observation outputs, WriteData and PCValue.
- Generates the core's clock (ProcClk) from the board clock, in free-run or single-step mode.
- Captures both values once per processor cycle and shows them as hex on an 8-digit multiplexed seven-segment display.
- Sits between the core top level and the FPGA pins.

Parameters:
- PROC_HALF, 50000000: board-clock cycles per ProcClk half-period in run mode and per high pulse in step mode; minimum 2.
- REFRESH_DIV, 100000: board-clock cycles each digit stays lit; minimum 2.
- DEBOUNCE_CYCLES, 1000000: cycles StepBtn must be stable before a level change is accepted.

Ports:
- Clk  in  1  board clock; every register in the block runs on its rising edge.
- Rst  in  1  asynchronous, active-low reset; asserts immediately, deassertion is synchronised by the board reset tree.
- WriteData  in  32  write-back data from the core.
- PCValue  in  32  PC+4 value from the core.
- StepMode  in  1  0 = free-run, 1 = single-step; asynchronous switch input.
- StepBtn  in  1  raw push-button; asynchronous.
- ProcClk  out  1  registered clock that drives the core's Clk.
- An  out  8  digit enables, active-low.
- Seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- Dp  out  1  decimal point, active-low.

Behaviour:
- Reset values: ProcClk=0, An=8'hFF, Seg=7'h7F, Dp=1. Capture registers, counters and FSM go to 0 / CLK_LO. Reset applies immediately, including mid-pulse; no partial pulse completes.
- StepMode: 2-flop synchronised before use.
- ProcClk FSM, states CLK_LO and CLK_HI, with half counter hc of width $clog2(PROC_HALF):
  - CLK_LO, run mode: hc counts to PROC_HALF-1, then enters CLK_HI with hc cleared.
  - CLK_LO, step mode: hc is held at 0; a step pulse enters CLK_HI.
  - CLK_HI: ProcClk=1; hc counts to PROC_HALF-1, then returns to CLK_LO.
  - ProcClk is registered as (state==CLK_HI).
- Mode changes take effect only at the next CLK_LO decision point; a high phase in progress always completes its full PROC_HALF.
- Step pulses arriving in CLK_HI, or in CLK_LO while in run mode, are discarded, not queued.
- Capture: a registered edge detector on ProcClk raises cap_en one Clk after the ProcClk rising edge. On cap_en, PCValue and WriteData are loaded into pc_q and wd_q.
  - Inputs are already stable: the core's registers update on that same ProcClk edge and have settled within one board cycle.
- Scan: rc counts 0..REFRESH_DIV-1, wraps, and advances digit index d (3 bits, wraps 7->0). An = ~(8'b1 << d).
  - Digits 7..4 show pc_q[15:0], digit 7 most significant.
  - Digits 3..0 show wd_q[15:0], digit 3 most significant.
- Nibble decode: standard hex 0-F, active-low. The decoded Seg is registered together with An so both change on the same edge.
- Dp=0 on digit 4 only, as a separator; Dp=1 otherwise.
- Simultaneous cap_en and digit advance: the new digit already shows the newly captured value.

Optional Feature:
- Macro PIPE_DISP_HIGH_HALF_EN.
- Defined: adds input HalfSel (1 bit, synchronised). HalfSel=1 shows bits [31:16] of both captured values, HalfSel=0 shows [15:0]. Dp additionally lights on digit 0 while HalfSel=1.
- Undefined: no HalfSel port; only [15:0] is shown.

Decomposition:
- Shared package pipeline_disp_pkg holds:
  - clk_state_t enum (CLK_LO, CLK_HI);
  - the 16-entry active-low hex segment constant table;
  - constant DIGITS=8.
- One sub-module, btn_debounce (parameter DEBOUNCE_CYCLES):
  - 2-flop synchroniser, stable counter, debounced level;
  - emits a single-cycle pulse on the debounced 0->1 edge;
  - counter restarts on any raw change.

Test Plan (PROC_HALF=3, REFRESH_DIV=4, DEBOUNCE_CYCLES=5):
- Reset, then StepMode=0 -> ProcClk has period 6 Clk (3 high, 3 low); An walks FE,FD,FB,...,7F, 4 Clk per digit; Rst low mid-high -> ProcClk=0 and An=FF in the same cycle.
- PCValue=32'h0000ABCD, WriteData=32'h00001234, run mode -> after the next ProcClk rise plus 1 Clk, digits 7..0 show A,b,C,d,1,2,3,4; Seg for 'A'=7'b0001000; Dp=0 only while An=8'hEF.
- StepMode=1, StepBtn bounces 0/1 every 2 Clk, then holds 1 for 8 Clk -> exactly one ProcClk pulse, 3 Clk wide; a second press during the pulse -> no extra pulse.
- Inputs change while ProcClk is low in step mode -> display unchanged until the next step-induced rising edge.
- StepMode toggled 0->1 during CLK_HI -> high phase lasts exactly 3 Clk, then ProcClk holds 0 until a step pulse.
- PIPE_DISP_HIGH_HALF_EN, HalfSel=1, PCValue=32'hDEAD0000 -> digits 7..4 show d,E,A,d; Dp low on digits 4 and 0.
